qslave_regs: RTL

QBUS slave (responder) with a small bank of word registers in the I/O page. It is the target-side counterpart to the DMA master (qmaster2908).
- Latches address on RSYNC assertion and decodes it against a base window.
- Answers DATI, DATO, DATOB and DATIO cycles by driving TRPLY and, for reads, TDAL with its enable.
- Gives the master bench a real responder, and later serves as the CSR block of the QSIC.

---
 rtl/qslave_regs.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/qslave_regs.sv
// QBUS slave with a small bank of word registers in the I/O page.
// Answers DATI, DATO, DATOB and DATIO cycles with a programmable RPLY delay.
module qslave_regs #(
    parameter logic [12:0] BASE       = 13'o17740,
    parameter int          NREGS      = 8,
    parameter int          RPLY_DELAY = 1
) (
    input  logic        qclk,
    input  logic        reset_L,
    input  logic        RINIT,
    input  logic        RSYNC,
    input  logic        RDIN,
    input  logic        RDOUT,
    input  logic        RWTBT,
    input  logic        RBS7,
    input  logic [21:0] RDAL,
    output logic        TRPLY,
    output logic [15:0] TDAL,
    output logic        assert_data,
    output logic        selected
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [2:0] {
        IDLE, MISS, WAIT, RDLY, WDLY, REPLY
    } state_t;

    state_t        state_q, state_d;
    logic          sync_q;
    logic          rise;
    logic [11:0]   off;
    logic          hit;
    logic [IW-1:0] idx_q;
    logic          odd_q;
    logic          rd_q;
    logic [2:0]    cnt_q;
    logic [15:0]   regs_q [NREGS];
    logic [15:0]   tdal_q;
    logic          trply_q, trply_d;
    logic          adat_q, adat_d;
    logic          sel_q, sel_d;
    logic          strobe;
    logic          load;
    logic          commit;
    logic          rst;

    assign rst    = !reset_L || RINIT;
    assign rise   = RSYNC & ~sync_q;
    assign off    = RDAL[12:1] - BASE[12:1];
    assign hit    = RBS7 & (&RDAL[21:13])
                  & (RDAL[12:1] >= BASE[12:1])
                  & (off < 12'(NREGS));
    assign strobe = rd_q ? RDIN : RDOUT;
    assign load   = (state_q == WAIT)
                  & ((state_d == RDLY) | (state_d == WDLY));
    assign commit = (state_q == WDLY) & (state_d == REPLY);

    // Left unreset so a SYNC held across INIT is not seen as a new edge.
    always_ff @(posedge qclk) begin
        sync_q <= RSYNC;
    end

    always_ff @(posedge qclk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rise) state_d = hit ? WAIT : MISS;
            end
            MISS: begin
                if (!RSYNC) state_d = IDLE;
            end
            WAIT: begin
                if (!RSYNC)     state_d = IDLE;
                else if (RDIN)  state_d = RDLY;
                else if (RDOUT) state_d = WDLY;
            end
            RDLY, WDLY: begin
                if (!RSYNC)           state_d = IDLE;
                else if (cnt_q == '0) state_d = REPLY;
            end
            REPLY: begin
                if (!RSYNC)      state_d = IDLE;
                else if (!strobe) state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        trply_d = (state_d == REPLY);
        sel_d   = (state_d == WAIT) | (state_d == RDLY)
                | (state_d == WDLY) | (state_d == REPLY);
        adat_d  = rd_q
                & ((state_q == RDLY) | (state_q == REPLY))
                & ((state_d == RDLY) | (state_d == REPLY));
    end

    always_ff @(posedge qclk) begin
        if (rst) begin
            trply_q <= 1'b0;
            adat_q  <= 1'b0;
            sel_q   <= 1'b0;
            tdal_q  <= '0;
            idx_q   <= '0;
            odd_q   <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            trply_q <= trply_d;
            adat_q  <= adat_d;
            sel_q   <= sel_d;
            if (state_q == IDLE && rise) begin
                idx_q <= off[IW-1:0];
                odd_q <= RDAL[0];
            end
            if (load) begin
                rd_q  <= RDIN;
                cnt_q <= 3'(RPLY_DELAY);
                if (RDIN) tdal_q <= regs_q[idx_q];
            end else if ((state_q == RDLY || state_q == WDLY)
                         && cnt_q != '0) begin
                cnt_q <= cnt_q - 3'd1;
            end
            // Odd-byte writes take the byte from the high data lane.
            if (commit) begin
                unique case (1'b1)
                    !RWTBT:
                        regs_q[idx_q] <= RDAL[15:0];
                    RWTBT && !odd_q:
                        regs_q[idx_q][7:0] <= RDAL[7:0];
                    RWTBT && odd_q:
                        regs_q[idx_q][15:8] <= RDAL[15:8];
                endcase
            end
        end
    end

    assign TRPLY       = trply_q;
    assign TDAL        = tdal_q;
    assign assert_data = adat_q;
    assign selected    = sel_q;

endmodule
